q_byte_serializer: RTL and testbench

//  Downstream stage of the registered array mux (ar_m): takes its 8-bit q word and shifts it out serially.
//  A one-entry holding register accepts the next word while the current one is still shifting.

---
 rtl/ser_pkg.sv | 25 ++
 rtl/q_byte_serializer_bit_timer.sv | 31 +++
 rtl/q_byte_serializer.sv | 137 +++++++++++++
 tb/tb_q_byte_serializer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared types and sizing helpers for the q byte serializer.
// Build option: define SER_PARITY_EN to append an even-parity bit to each frame.
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef SER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_bits(input int width);
        return width + PARITY_BITS;
    endfunction

    // Counter wide enough to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/q_byte_serializer_bit_timer.sv
// Bit-period divider: tc marks the last clk cycle of each serial bit.
// Cleared while idle so every frame starts on a fresh bit period.
module q_byte_serializer_bit_timer
    import ser_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);

    localparam int TW = cnt_width(CLKS_PER_BIT);

    logic [TW-1:0] count;

    assign tc = en && (count == TW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + TW'(1);
        end
    end

endmodule

// File: rtl/q_byte_serializer.sv
// Parallel-to-serial stage behind ar_m with a one-word holding register.
// Build option: SER_PARITY_EN adds an even-parity bit after the data bits.
module q_byte_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             busy,
    output logic             done
);

    localparam int FRAME_BITS = frame_bits(WIDTH);
    localparam int BIW        = cnt_width(FRAME_BITS);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0]      hold;
    logic                  hold_full;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] load_word;
    logic [FRAME_BITS-1:0] shifted;
    logic [BIW-1:0]        bit_idx;
    logic                  accept;
    logic                  load;
    logic                  advance;
    logic                  last;
    logic                  tc;
    logic                  out_bit;

    assign accept = din_valid && din_ready;

`ifdef SER_PARITY_EN
    logic parity;
    assign parity    = ^hold;
    assign load_word = MSB_FIRST ? {hold, parity} : {parity, hold};
`else
    assign load_word = hold;
`endif

    // The outgoing bit always sits at the end the shifter moves toward.
    assign shifted = MSB_FIRST ? {shreg[FRAME_BITS-2:0], 1'b0}
                               : {1'b0, shreg[FRAME_BITS-1:1]};
    assign out_bit = MSB_FIRST ? shreg[FRAME_BITS-1] : shreg[0];

    q_byte_serializer_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == IDLE),
        .en   (state_q == SHIFT),
        .tc   (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hold_full) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tc) begin
                    if (bit_idx == BIW'(FRAME_BITS - 1)) begin
                        last = 1'b1;
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
            din_ready <= 1'b1;
        end else begin
            if (accept) begin
                hold      <= din;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            // Lags hold_full by one cycle after a load, drops at once on accept.
            din_ready <= accept ? 1'b0 : !hold_full;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (load) begin
            shreg   <= load_word;
            bit_idx <= '0;
        end else if (advance) begin
            shreg   <= shifted;
            bit_idx <= bit_idx + BIW'(1);
        end
    end

    assign sdo_valid = (state_q == SHIFT);
    assign sdo       = sdo_valid && out_bit;
    assign busy      = sdo_valid || hold_full;
    assign done      = last;

endmodule

// File: tb/tb_q_byte_serializer.sv
// Bench for q_byte_serializer: two configurations checked against a frame-timeline model.
// Frames are scheduled from accept times; every cycle's outputs are derived from that schedule.
module tb_q_byte_serializer;

`ifdef SER_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    typedef struct {
        int         acc;
        int         st;
        logic [7:0] w;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din [2];
    logic       din_valid [2];
    logic       din_ready [2];
    logic       sdo [2];
    logic       sdo_valid [2];
    logic       busy [2];
    logic       done [2];
    logic       acc_pend [2];

    int     cyc;
    int     checks;
    int     errors;
    frame_t fq0 [$];
    frame_t fq1 [$];

    always #5 clk = ~clk;

    q_byte_serializer #(
        .WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .sdo(sdo[0]), .sdo_valid(sdo_valid[0]),
        .busy(busy[0]), .done(done[0])
    );

    q_byte_serializer #(
        .WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .sdo(sdo[1]), .sdo_valid(sdo_valid[1]),
        .busy(busy[1]), .done(done[1])
    );

    function automatic int cpb_of(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic bit msb_of(int i);
        return (i == 0);
    endfunction

    function automatic int fend(frame_t f, int i);
        return f.st + FB * cpb_of(i);
    endfunction

    // Bit k of the transmitted frame for word w.
    function automatic logic fbit(logic [7:0] w, int k, bit msb);
        logic [7:0] v;
        v = w;
        if (k >= 8) return ^v;
        return msb ? v[7-k] : v[k];
    endfunction

    task automatic chk(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic add_frame(int i, logic [7:0] w);
        frame_t f;
        int     prev_end;
        prev_end = 0;
        if (i == 0 && fq0.size() > 0) prev_end = fend(fq0[$], i);
        if (i == 1 && fq1.size() > 0) prev_end = fend(fq1[$], i);
        f.acc = cyc;
        f.st  = (cyc + 1 > prev_end) ? cyc + 1 : prev_end;
        f.w   = w;
        if (i == 0) fq0.push_back(f);
        else        fq1.push_back(f);
    endtask

    task automatic check_dut(int i);
        frame_t q [$];
        logic   e_valid, e_sdo, e_done, e_hold, e_rdy_lo;
        int     k;
        if (i == 0) begin
            while (fq0.size() > 0 && fend(fq0[0], i) < cyc) void'(fq0.pop_front());
            q = fq0;
        end else begin
            while (fq1.size() > 0 && fend(fq1[0], i) < cyc) void'(fq1.pop_front());
            q = fq1;
        end
        e_valid  = 1'b0;
        e_sdo    = 1'b0;
        e_done   = 1'b0;
        e_hold   = 1'b0;
        e_rdy_lo = 1'b0;
        foreach (q[n]) begin
            if (cyc >= q[n].st && cyc < fend(q[n], i)) begin
                k       = (cyc - q[n].st) / cpb_of(i);
                e_valid = 1'b1;
                e_sdo   = fbit(q[n].w, k, msb_of(i));
                e_done  = (cyc == fend(q[n], i) - 1);
            end
            if (cyc >= q[n].acc && cyc < q[n].st)  e_hold = 1'b1;
            if (cyc >= q[n].acc && cyc <= q[n].st) e_rdy_lo = 1'b1;
        end
        chk($sformatf("d%0d c%0d sdo_valid", i, cyc), sdo_valid[i], e_valid);
        chk($sformatf("d%0d c%0d sdo", i, cyc), sdo[i], e_sdo);
        chk($sformatf("d%0d c%0d done", i, cyc), done[i], e_done);
        chk($sformatf("d%0d c%0d busy", i, cyc), busy[i], e_valid | e_hold);
        chk($sformatf("d%0d c%0d din_ready", i, cyc), din_ready[i], !e_rdy_lo);
    endtask

    task automatic tick();
        for (int i = 0; i < 2; i++) acc_pend[i] = din_valid[i] && din_ready[i];
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc_pend[i]) begin
                add_frame(i, din[i]);
                din_valid[i] = 1'b0;
            end
        end
        for (int i = 0; i < 2; i++) check_dut(i);
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic send(int i, logic [7:0] w);
        int n;
        n            = 0;
        din[i]       = w;
        din_valid[i] = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc_pend[i] && n < 100);
        chk($sformatf("d%0d accept %h", i, w), acc_pend[i], 1'b1);
        din_valid[i] = 1'b0;
    endtask

    task automatic reset_checks(string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s d%0d sdo", tag, i), sdo[i], 1'b0);
            chk($sformatf("%s d%0d sdo_valid", tag, i), sdo_valid[i], 1'b0);
            chk($sformatf("%s d%0d busy", tag, i), busy[i], 1'b0);
            chk($sformatf("%s d%0d done", tag, i), done[i], 1'b0);
            chk($sformatf("%s d%0d din_ready", tag, i), din_ready[i], 1'b1);
        end
    endtask

    task automatic do_reset(int edges);
        rst          = 1'b1;
        din_valid[0] = 1'b0;
        din_valid[1] = 1'b0;
        acc_pend[0]  = 1'b0;
        acc_pend[1]  = 1'b0;
        fq0.delete();
        fq1.delete();
        repeat (edges) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        reset_checks("reset");
        #1;
        rst = 1'b0;
    endtask

    initial begin
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        din[0]       = '0;
        din[1]       = '0;
        din_valid[0] = 1'b0;
        din_valid[1] = 1'b0;
        rst          = 1'b1;

        do_reset(3);
        idle(2);

        send(0, 8'hA5);
        idle(12);

        send(0, 8'hFF);
        send(0, 8'h00);
        idle(20);

        send(1, 8'h81);
        idle(40);

        send(0, 8'hF0);
        send(0, 8'h55);
        while (!(fq0.size() > 0 && cyc == fq0[0].st + 3)) tick();
        #1;
        rst = 1'b1;
        #1;
        reset_checks("midframe");
        do_reset(2);
        idle(1);
        send(0, 8'h3C);
        idle(12);

`ifdef SER_PARITY_EN
        send(0, 8'h07);
        idle(12);
        send(0, 8'h03);
        idle(12);
`endif

        repeat (400) begin
            for (int i = 0; i < 2; i++) begin
                if (!din_valid[i] && $urandom_range(0, 2) == 0) begin
                    din[i]       = 8'($urandom);
                    din_valid[i] = 1'b1;
                end
            end
            tick();
        end
        din_valid[0] = 1'b0;
        din_valid[1] = 1'b0;
        idle(80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
